muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 151 +++++++++++++++
 tb/tb_muldiv_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential HI/LO multiply/divide unit: fixed-latency multiply, 32-cycle restoring divide,
// direct MTHI/MTLO writes, flush abort.
//
// state | meaning
// IDLE  | ready to accept an operation
// MUL   | waiting out the multiply latency
// DIV   | one restoring-division quotient bit per cycle
// DONE  | result valid, HI/LO load on the edge that ends this cycle
module muldiv_seq #(
   parameter int MULT_LAT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid_in,
   input  logic [3:0]  funct,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   input  logic        flush,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] hi_wdata,
   input  logic [31:0] lo_wdata,
   output logic        ready_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

   localparam logic [3:0] F_MULT  = 4'b1011;
   localparam logic [3:0] F_MULTU = 4'b1100;
   localparam logic [3:0] F_DIV   = 4'b1101;
   localparam logic [3:0] F_DIVU  = 4'b1110;
   localparam logic [4:0] MUL_LOAD = 5'(MULT_LAT - 1);
   localparam logic [4:0] DIV_LOAD = 5'd31;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [31:0] op_a, op_b, rem, quo;
   logic        op_signed, op_div;
   logic        legal, is_div_op, accept;
   logic        neg_a, neg_b;
   logic [31:0] a_mag_in, b_mag;
   logic [32:0] shifted, diff;
   logic [63:0] prod;
   logic [31:0] q_fix, r_fix, res_hi, res_lo;

   assign legal     = (funct == F_MULT) | (funct == F_MULTU) | (funct == F_DIV) | (funct == F_DIVU);
   assign is_div_op = (funct == F_DIV) | (funct == F_DIVU);
   assign accept    = valid_in & (state == IDLE) & legal & ~flush;

   assign ready_in = (state == IDLE);
   assign busy     = ~ready_in;
   assign done     = (state == DONE);

   // Dividend magnitude goes straight into the quotient shift register at accept
   assign a_mag_in = ((funct == F_DIV) && in1[31]) ? (~in1 + 32'd1) : in1;

   assign neg_a   = op_signed & op_a[31];
   assign neg_b   = op_signed & op_b[31];
   assign b_mag   = neg_b ? (~op_b + 32'd1) : op_b;
   assign shifted = {rem, quo[31]};
   assign diff    = shifted - {1'b0, b_mag};

   // neg_a/neg_b double as the sign-extension bits for the signed product
   assign prod  = {{32{neg_a}}, op_a} * {{32{neg_b}}, op_b};
   assign q_fix = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
   assign r_fix = neg_a ? (~rem + 32'd1) : rem;

   always_comb begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      if (op_div) begin
         if (op_b == 32'd0) begin
            res_hi = op_a;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_hi = r_fix;
            res_lo = q_fix;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept) state_nxt = is_div_op ? DIV : MUL;
         MUL, DIV: begin
            if (flush)            state_nxt = IDLE;
            else if (cnt == 5'd0) state_nxt = DONE;
         end
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt       <= 5'd0;
         op_a      <= 32'd0;
         op_b      <= 32'd0;
         op_signed <= 1'b0;
         op_div    <= 1'b0;
         rem       <= 32'd0;
         quo       <= 32'd0;
      end else begin
         if (accept) begin
            op_a      <= in1;
            op_b      <= in2;
            op_signed <= (funct == F_MULT) | (funct == F_DIV);
            op_div    <= is_div_op;
            cnt       <= is_div_op ? DIV_LOAD : MUL_LOAD;
            rem       <= 32'd0;
            quo       <= a_mag_in;
         end else if (((state == MUL) || (state == DIV)) && (cnt != 5'd0)) begin
            cnt <= cnt - 5'd1;
         end
         if (state == DIV) begin
            if (!diff[32]) begin
               rem <= diff[31:0];
               quo <= {quo[30:0], 1'b1};
            end else begin
               rem <= shifted[31:0];
               quo <= {quo[30:0], 1'b0};
            end
         end
      end
   end

   // The commit takes both registers, so a coincident direct write loses
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (state == DONE) begin
         hi <= res_hi;
         lo <= res_lo;
      end else begin
         if (hi_we) hi <= hi_wdata;
         if (lo_we) lo <= lo_wdata;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random operations
// against an arithmetic reference model.
module tb_muldiv_seq;

   localparam int MULT_LAT = 2;
   localparam logic [3:0] F_MULT  = 4'b1011;
   localparam logic [3:0] F_MULTU = 4'b1100;
   localparam logic [3:0] F_DIV   = 4'b1101;
   localparam logic [3:0] F_DIVU  = 4'b1110;

   logic        clk = 1'b0;
   logic        resetn;
   logic        valid_in, flush, hi_we, lo_we;
   logic [3:0]  funct;
   logic [31:0] in1, in2, hi_wdata, lo_wdata;
   logic        ready_in, busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   muldiv_seq #(.MULT_LAT(MULT_LAT)) dut (
      .clk(clk), .resetn(resetn), .valid_in(valid_in), .funct(funct),
      .in1(in1), .in2(in2), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
      .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .ready_in(ready_in),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: {hi, lo} from plain integer arithmetic
   function automatic logic [63:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] ua, ub;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f)
         F_MULT:  return 64'(sa * sb);
         F_MULTU: return ua * ub;
         F_DIVU:  return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // Issue one operation at a negedge, wait for done, optionally poke flush/direct writes in DONE
   task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit flush_done, input bit hwe, input bit lwe);
      logic [63:0] res;
      int k, lat;
      res = model(f, a, b);
      lat = ((f == F_MULT) || (f == F_MULTU)) ? MULT_LAT + 1 : 33;
      valid_in = 1'b1; funct = f; in1 = a; in2 = b;
      check("ready_before_accept", ready_in, 1);
      @(negedge clk);
      valid_in = 1'b0; funct = 4'($urandom); in1 = $urandom; in2 = $urandom;
      k = 1;
      check("busy_after_accept", busy, 1);
      while (done !== 1'b1 && k <= 40) begin
         @(negedge clk);
         k++;
      end
      check("latency", k, lat);
      check("ready_in_done", ready_in, 0);
      flush = flush_done;
      hi_we = hwe; hi_wdata = 32'h0000_1234;
      lo_we = lwe; lo_wdata = 32'h0000_5678;
      valid_in = 1'b1; funct = F_MULTU;
      @(negedge clk);
      flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; valid_in = 1'b0;
      exp_hi = res[63:32];
      exp_lo = res[31:0];
      check("hi", hi, exp_hi);
      check("lo", lo, exp_lo);
      check("done_single_pulse", done, 0);
      check("ready_after_done", ready_in, 1);
   endtask

   initial begin
      int ndone;
      logic [3:0] fsel [4];
      fsel[0] = F_MULT; fsel[1] = F_MULTU; fsel[2] = F_DIV; fsel[3] = F_DIVU;
      resetn = 1'b0; valid_in = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      funct = 4'd0; in1 = 32'd0; in2 = 32'd0; hi_wdata = 32'd0; lo_wdata = 32'd0;
      repeat (2) @(negedge clk);
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      check("reset_ready", ready_in, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      resetn = 1'b1;

      run_op(F_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0, 0);
      check("mult_neg2x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
      check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
      check("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(F_DIVU, 32'd100, 32'd0, 0, 0, 0);
      check("divu_by_zero", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
      run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      check("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});
      run_op(F_DIV, 32'hFFFF_FF00, 32'd0, 0, 0, 0);
      check("div_neg_by_zero", {hi, lo}, {32'hFFFF_FF00, 32'hFFFF_FFFF});

      // Direct writes in DONE lose to the result; flush in DONE is ignored
      run_op(F_MULTU, 32'hFFFF_FFFF, 32'd6, 1, 1, 1);
      check("done_write_hi", hi, 32'd5);
      check("done_write_lo", lo, 32'hFFFF_FFFA);

      hi_we = 1'b1; hi_wdata = 32'h0000_1234;
      @(negedge clk);
      hi_we = 1'b0;
      exp_hi = 32'h0000_1234;
      check("mthi_idle", hi, exp_hi);
      lo_we = 1'b1; lo_wdata = 32'hCAFE_0001;
      @(negedge clk);
      lo_we = 1'b0;
      exp_lo = 32'hCAFE_0001;
      check("mtlo_idle", lo, exp_lo);

      // Illegal opcodes are no-ops
      valid_in = 1'b1; funct = 4'b0000; in1 = 32'd9; in2 = 32'd3;
      @(negedge clk);
      check("illegal0_ready", ready_in, 1);
      funct = 4'b1111;
      @(negedge clk);
      check("illegal15_ready", ready_in, 1);
      valid_in = 1'b0;
      check("illegal_hi", hi, exp_hi);

      // Flush in IDLE blocks an accept
      valid_in = 1'b1; funct = F_DIVU; flush = 1'b1;
      @(negedge clk);
      valid_in = 1'b0; flush = 1'b0;
      check("flush_idle_ready", ready_in, 1);

      // Flush mid-divide
      valid_in = 1'b1; funct = F_DIVU; in1 = 32'd1000; in2 = 32'd7;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_ready", ready_in, 1);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      check("flush_no_done", ndone, 0);
      check("flush_hi", hi, exp_hi);
      check("flush_lo", lo, exp_lo);

      // Reset mid-divide
      valid_in = 1'b1; funct = F_DIV; in1 = 32'd77; in2 = 32'd5;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      #1;
      exp_hi = 32'd0; exp_lo = 32'd0;
      check("rst_mid_hi", hi, exp_hi);
      check("rst_mid_lo", lo, exp_lo);
      check("rst_mid_ready", ready_in, 1);
      check("rst_mid_done", done, 0);
      @(negedge clk);
      resetn = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      check("rst_no_done", ndone, 0);

      // Random operations, including occasional zero divisors
      for (int n = 0; n < 24; n++) begin
         logic [3:0] f;
         logic [31:0] a, b;
         f = fsel[$urandom_range(3)];
         a = $urandom;
         b = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(3) == 0) b = b >> $urandom_range(31);
         run_op(f, a, b, 0, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
